// File: rtl/sync_fifo_param.sv
// Parametrised synchronous RAM-based FIFO with a selectable show-ahead or registered read port.
// It provides an occupancy count, threshold flags and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 4,
    parameter int AE_THRESH  = 4,
    parameter int FWFT       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en_in,
    input  logic                  rd_ack_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty_out,
    output logic                  full_out,
    output logic                  almost_empty_out,
    output logic                  almost_full_out,
    output logic [ADDR_WIDTH:0]   count_out,
    output logic                  overflow_out,
    output logic                  underflow_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

    if (!(AE_THRESH >= 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_params
        $error("sync_fifo_param: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  empty, full;
    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   ptr_diff;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_C);
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        rd_acc   = rd_ack_in && !empty && !clr_in;
        wr_acc   = wr_en_in && (!full || rd_acc) && !clr_in;
        rd_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
        ptr_diff = wr_ptr_q - rd_ptr_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (clr_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
            if (wr_en_in && !wr_acc) ovf_d = 1'b1;
            if (rd_ack_in && empty)  udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is never reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end

    always_comb begin
        count_out        = count_q;
        empty_out        = empty;
        full_out         = full;
        almost_full_out  = (count_q >= AF_C);
        almost_empty_out = (count_q <= AE_C);
        overflow_out     = ovf_q;
        underflow_out    = udf_q;
    end

    if (FWFT != 0) begin : g_show_ahead
        always_comb begin
            data_out  = mem[rd_addr];
            valid_out = !empty;
        end
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  valid_q, valid_d;

        always_comb begin
            dout_d  = dout_q;
            valid_d = 1'b0;
            if (rd_acc) begin
                dout_d  = mem[rd_addr];
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_d;
                valid_q <= valid_d;
            end
        end

        always_comb begin
            data_out  = dout_q;
            valid_out = valid_q;
        end
    end

    // Full/empty come from the count; the wide pointers must always agree with it.
    a_ptr_count: assert property (@(posedge clk) disable iff (reset) ptr_diff == count_q)
        else $error("sync_fifo_param: pointer distance disagrees with count");

endmodule
